// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state enum and width helpers for the SAD minimum tracker.
package sad_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } sad_state_e;

  function automatic int sad_w(input int width, input int win_pixels);
    return width + $clog2(win_pixels);
  endfunction

  function automatic int idx_w(input int cand_num);
    return $clog2(cand_num);
  endfunction

endpackage

// File: rtl/pixel_absdiff.sv
// rtl/pixel_absdiff.sv - combinational unsigned |a-b| for one pixel pair.
module pixel_absdiff #(
  parameter int width = 5
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] d
);

  assign d = (a > b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_min_tracker.sv
// rtl/sad_min_tracker.sv - streaming SAD matcher reporting the minimum-SAD candidate.
// SAD_REG_ABS_EN: register |a-b| (with valid/last/index tag) ahead of the accumulator.
module sad_min_tracker
  import sad_pkg::*;
#(
  parameter int width      = 5,
  parameter int win_pixels = 64,
  parameter int cand_num   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [width-1:0]                      s_a,
  input  logic [width-1:0]                      s_b,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [idx_w(cand_num)-1:0]            m_idx,
  output logic [sad_w(width, win_pixels)-1:0]   m_sad
);

  localparam int SW = sad_w(width, win_pixels);
  localparam int IW = idx_w(cand_num);
  localparam int PW = $clog2(win_pixels);

  sad_state_e      state_q, state_d;
  logic            s_ready_q, s_ready_d;
  logic            m_valid_q, m_valid_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [IW-1:0]   cand_cnt_q, cand_cnt_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   min_sad_q, min_sad_d;
  logic [IW-1:0]   min_idx_q, min_idx_d;

  logic [width-1:0] abs_diff;
  logic             accept, last_pix, last_cand;
  logic             c_valid, c_last;
  logic [width-1:0] c_abs;
  logic [IW-1:0]    c_idx;
  logic [SW-1:0]    win_sad;

  pixel_absdiff #(.width(width)) u_absdiff (
    .a(s_a),
    .b(s_b),
    .d(abs_diff)
  );

  assign accept    = s_valid && s_ready_q;
  assign last_pix  = (pix_cnt_q == PW'(win_pixels - 1));
  assign last_cand = (cand_cnt_q == IW'(cand_num - 1));

`ifdef SAD_REG_ABS_EN
  logic             stg_valid_q, stg_last_q;
  logic [width-1:0] stg_abs_q;
  logic [IW-1:0]    stg_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_last_q  <= 1'b0;
      stg_abs_q   <= '0;
      stg_idx_q   <= '0;
    end else begin
      stg_valid_q <= accept;
      stg_last_q  <= accept && last_pix;
      stg_abs_q   <= abs_diff;
      stg_idx_q   <= cand_cnt_q;
    end
  end

  assign c_valid = stg_valid_q;
  assign c_last  = stg_last_q;
  assign c_abs   = stg_abs_q;
  assign c_idx   = stg_idx_q;
`else
  assign c_valid = accept;
  assign c_last  = last_pix;
  assign c_abs   = abs_diff;
  assign c_idx   = cand_cnt_q;
`endif

  assign win_sad = acc_q + {{PW{1'b0}}, c_abs};

  always_comb begin
    state_d    = state_q;
    s_ready_d  = s_ready_q;
    m_valid_d  = m_valid_q;
    pix_cnt_d  = pix_cnt_q;
    cand_cnt_d = cand_cnt_q;
    acc_d      = acc_q;
    min_sad_d  = min_sad_q;
    min_idx_d  = min_idx_q;

    if (accept) begin
      if (last_pix) begin
        pix_cnt_d  = '0;
        cand_cnt_d = last_cand ? '0 : cand_cnt_q + 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end

    // Strict less-than keeps the lower index on ties; candidate 0 seeds the minimum.
    if (c_valid) begin
      if (c_last) begin
        acc_d = '0;
        if (c_idx == '0 || win_sad < min_sad_q) begin
          min_sad_d = win_sad;
          min_idx_d = c_idx;
        end
      end else begin
        acc_d = win_sad;
      end
    end

    case (state_q)
      ACCUM: begin
        s_ready_d = 1'b1;
        if (accept && last_pix && last_cand) begin
          s_ready_d = 1'b0;
`ifdef SAD_REG_ABS_EN
          state_d   = DRAIN;
`else
          state_d   = HOLD;
          m_valid_d = 1'b1;
`endif
        end
      end
      DRAIN: begin
        state_d   = HOLD;
        m_valid_d = 1'b1;
      end
      HOLD: begin
        if (m_ready) begin
          state_d    = ACCUM;
          s_ready_d  = 1'b1;
          m_valid_d  = 1'b0;
          pix_cnt_d  = '0;
          cand_cnt_d = '0;
          acc_d      = '0;
          min_sad_d  = '0;
          min_idx_d  = '0;
        end
      end
      default: begin
        state_d   = ACCUM;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      pix_cnt_q  <= '0;
      cand_cnt_q <= '0;
      acc_q      <= '0;
      min_sad_q  <= '0;
      min_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      pix_cnt_q  <= pix_cnt_d;
      cand_cnt_q <= cand_cnt_d;
      acc_q      <= acc_d;
      min_sad_q  <= min_sad_d;
      min_idx_q  <= min_idx_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_idx   = min_idx_q;
  assign m_sad   = min_sad_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb/tb_sad_min_tracker.sv - randomized self-checking bench for sad_min_tracker against a search model.
module tb_sad_min_tracker;

  localparam int W  = 5;
  localparam int WP = 4;
  localparam int CN = 3;
  localparam int SW = W + 2;
  localparam int IW = 2;
  localparam int NP = WP * CN;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_a = '0;
  logic [W-1:0]  s_b = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [IW-1:0] m_idx;
  logic [SW-1:0] m_sad;

  int checks = 0;
  int failures = 0;
  int pa[NP];
  int pb[NP];

  sad_min_tracker #(.width(W), .win_pixels(WP), .cand_num(CN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_idx(m_idx), .m_sad(m_sad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Per-candidate SADs by plain arithmetic; the first strictly smaller one wins.
  task automatic model(output int eidx, output int esad);
    int s, d;
    eidx = 0;
    esad = -1;
    for (int c = 0; c < CN; c++) begin
      s = 0;
      for (int p = 0; p < WP; p++) begin
        d = pa[c*WP+p] - pb[c*WP+p];
        s += (d < 0) ? -d : d;
      end
      if (esad < 0 || s < esad) begin
        esad = s;
        eidx = c;
      end
    end
  endtask

  task automatic load_basic();
    int a0[WP] = '{10, 3, 0, 31};
    int b0[WP] = '{3, 10, 0, 0};
    for (int p = 0; p < WP; p++) begin
      pa[p] = a0[p];      pb[p] = b0[p];
      pa[WP+p] = 5;       pb[WP+p] = 5;
      pa[2*WP+p] = 1;     pb[2*WP+p] = 2;
    end
  endtask

  task automatic load_const(input int a, input int b);
    for (int k = 0; k < NP; k++) begin
      pa[k] = a;
      pb[k] = b;
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < NP; k++) begin
      pa[k] = $urandom_range(0, 31);
      pb[k] = $urandom_range(0, 31);
    end
  endtask

  task automatic send_pairs(input int n, input int gap_pct);
    int k = 0;
    int budget = 0;
    logic acc;
    while (k < n && budget < 500) begin
      @(negedge clk);
      budget++;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_a = W'(pa[k]);
        s_b = W'(pb[k]);
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) k++;
    end
    if (k < n) check("send_timeout", k, n);
  endtask

  task automatic run_search(input string tag, input int gap_pct, input int bp_cycles);
    int eidx, esad;
    logic [IW-1:0] hidx;
    logic [SW-1:0] hsad;
    model(eidx, esad);
    send_pairs(NP, gap_pct);
    @(negedge clk);
    s_valid = 1'b0;
`ifdef SAD_REG_ABS_EN
    check({tag, "_lat_mvalid0"}, m_valid, 0);
    check({tag, "_lat_sready0"}, s_ready, 0);
    @(negedge clk);
`endif
    check({tag, "_mvalid"}, m_valid, 1);
    check({tag, "_sready_low"}, s_ready, 0);
    check({tag, "_idx"}, m_idx, eidx);
    check({tag, "_sad"}, m_sad, esad);
    hidx = m_idx;
    hsad = m_sad;
    for (int i = 0; i < bp_cycles; i++) begin
      s_valid = 1'b1;
      s_a = W'($urandom_range(0, 31));
      s_b = W'($urandom_range(0, 31));
      @(negedge clk);
      check({tag, "_bp_mvalid"}, m_valid, 1);
      check({tag, "_bp_sready"}, s_ready, 0);
      check({tag, "_bp_idx"}, m_idx, hidx);
      check({tag, "_bp_sad"}, m_sad, hsad);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({tag, "_post_sready"}, s_ready, 1);
    check({tag, "_post_mvalid"}, m_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_idx", m_idx, 0);
    check("rst_sad", m_sad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sready_after", s_ready, 1);

    load_basic();
    run_search("basic", 0, 0);
    load_const(2, 0);
    run_search("tie", 0, 0);
    load_const(31, 0);
    run_search("max", 0, 0);
    load_basic();
    run_search("bp", 0, 5);
    load_basic();
    run_search("gaps", 40, 0);

    load_basic();
    send_pairs(6, 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_sready", s_ready, 0);
    check("abort_mvalid", m_valid, 0);
    check("abort_sad", m_sad, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_sready_after", s_ready, 1);
    run_search("after_abort", 0, 0);

    for (int t = 0; t < 8; t++) begin
      load_random();
      run_search("rand", 30, t % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
